wide_add_sequencer: RTL
=======================

Name: wide_add_sequencer

Overview:
Multi-cycle controller that adds two wide operands using one narrow WIDTH-bit adder slice, processing one chunk per clock.
It latches the operands, walks chunk 0 (LSB) to chunk NUM_CHUNKS-1, and chains the carry between chunks in a register.
It uses a start/busy/done handshake.
It sits between a host request interface and the shared adder datapath, trading latency for area on wide additions.

Parameters:
WIDTH, 4, chunk width in bits (width of the adder slice), >=1
NUM_CHUNKS, 4, number of chunks per operand, >=2; total operand width TW = WIDTH*NUM_CHUNKS

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset
start  input  1  request pulse; sampled only when accepting (IDLE or DONE)
a  input  TW  operand A, sampled on accepted start
b  input  TW  operand B, sampled on accepted start
cin  input  1  carry-in, sampled on accepted start
busy  output  1  high while a job is in progress
done  output  1  one-cycle pulse, result valid
sum  output  TW  result, registered, holds until next completion
cout  output  1  final carry-out, registered, holds until next completion

Behaviour:
- Reset (rst=0, async): state=IDLE, chunk index=0, carry reg=0, operand regs=0, accumulator=0. busy=0, done=0, sum=0, cout=0. Takes effect immediately, including mid-job; the in-flight job is discarded and no done is issued.
- FSM states: IDLE, ADD, DONE.
- IDLE: start=1 at edge E0 latches a, b, cin; idx<=0; carry<=cin; ->ADD; busy=1 from E0. start=0: stay IDLE.
- ADD: at each edge, {c, s} = a[idx chunk] + b[idx chunk] + carry, using (WIDTH+1)-bit arithmetic.
  - s is written into the accumulator at bits [idx*WIDTH +: WIDTH]; carry<=c; idx<=idx+1.
  - On the edge processing idx=NUM_CHUNKS-1 (edge E_N, N=NUM_CHUNKS): sum<=full accumulator including the final chunk; cout<=c; busy<=0; done<=1; ->DONE.
- Latency: done is high in the cycle after edge E_N, i.e. N+1 edges after the start edge E0.
- sum and cout change only at E_N; partial results are never visible.
- DONE: done is high for exactly one cycle.
  - start=1 at this edge: accept the new job as in IDLE (latch, busy=1, done=0, ->ADD). Back-to-back jobs therefore have a period of N+1 cycles.
  - start=0: ->IDLE, done=0.
- start while in ADD is ignored. It is not queued, and the operands are unaffected.
- a, b, cin may change freely after the start edge; only the latched copies are used.
- idx width is clog2(NUM_CHUNKS), minimum 1. idx never wraps: the FSM leaves ADD at NUM_CHUNKS-1.
- Carry propagates across all chunks; e.g. all-ones + cin=1 ripples to cout=1 with sum=0.

Optional Feature:
Macro: WIDE_ADD_OVF_EN
- Defined:
  - Adds output port ovf (1 bit): two's-complement signed overflow of the full TW-bit add.
  - ovf = carry into MSB XOR carry out of MSB, computed in the last chunk.
  - Registered at E_N alongside sum/cout, reset to 0, held until the next completion.
- Not defined: port ovf and its logic do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles with start=1 and random a/b -> busy=0, done=0, sum=0, cout=0 throughout.
- Basic (WIDTH=4, NUM_CHUNKS=4): a=16'h00FF, b=16'h0001, cin=0, start pulsed at E0 -> busy 1 for 4 cycles; done=1 exactly 5 edges after E0; sum=16'h0100, cout=0.
- Full carry ripple: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1. Also a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, cout=0.
- Start while busy: start 16'h0001+16'h0001, then start=1 with a=16'hAAAA at E2 -> ignored; result sum=16'h0002 at the expected time; no second done follows.
- Back-to-back and mid-op reset:
  - start asserted in the DONE cycle with a=16'h8000, b=16'h8000 -> accepted; second done N+1 cycles later with sum=0, cout=1.
  - Separately, assert rst=0 at E2 of a job -> outputs 0 immediately, no done; a subsequent job completes correctly.
- With WIDE_ADD_OVF_EN: a=16'h7FFF, b=16'h0001 -> ovf=1, sum=16'h8000, cout=0. a=16'hFFFF, b=16'h0001 -> ovf=0, cout=1.

Source files
------------

// File: rtl/wide_add_if.sv
// Host-side handshake and operand/result bus for wide_add_sequencer.
// Carries the ovf result only when WIDE_ADD_OVF_EN is defined.
interface wide_add_if #(
    parameter int WIDTH      = 4,
    parameter int NUM_CHUNKS = 4
);
    localparam int TW = WIDTH * NUM_CHUNKS;

    logic          start;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          cin;
    logic          busy;
    logic          done;
    logic [TW-1:0] sum;
    logic          cout;
`ifdef WIDE_ADD_OVF_EN
    logic          ovf;

    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/wide_add_sequencer.sv
// Adds two WIDTH*NUM_CHUNKS-bit operands one WIDTH-bit chunk per clock, LSB chunk first.
// Optional signed-overflow output enabled by defining WIDE_ADD_OVF_EN.
module wide_add_sequencer #(
    parameter int WIDTH      = 4,
    parameter int NUM_CHUNKS = 4
) (
    input  logic         clk,
    input  logic         rst,
    wide_add_if.slave    bus
);
    localparam int TW   = WIDTH * NUM_CHUNKS;
    localparam int IDXW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state;
    logic [IDXW-1:0] idx;
    logic            carry;
    logic [TW-1:0]   a_q;
    logic [TW-1:0]   b_q;
    logic [TW-1:0]   acc;
    logic            busy_q;
    logic            done_q;
    logic [TW-1:0]   sum_q;
    logic            cout_q;

    logic [WIDTH:0]   slice;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf_bit;

    // Operands shift right and the accumulator fills from the top, so the
    // current chunk is always at bit 0 and chunk idx lands at [idx*WIDTH +: WIDTH].
    always_comb begin
        slice   = {1'b0, a_q[WIDTH-1:0]} + {1'b0, b_q[WIDTH-1:0]}
                + {{WIDTH{1'b0}}, carry};
        s       = slice[WIDTH-1:0];
        c       = slice[WIDTH];
        ovf_bit = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ s[WIDTH-1] ^ c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        carry  <= bus.cin;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= ADD;
                    end else begin
                        state  <= IDLE;
                    end
                end
                ADD: begin
                    a_q   <= a_q >> WIDTH;
                    b_q   <= b_q >> WIDTH;
                    carry <= c;
                    acc   <= {s, acc[TW-1:WIDTH]};
                    if (idx == LAST_IDX) begin
                        sum_q  <= {s, acc[TW-1:WIDTH]};
                        cout_q <= c;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WIDE_ADD_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (state == ADD && idx == LAST_IDX) begin
            ovf_q <= ovf_bit;
        end
    end

    assign bus.ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_bit;
`endif

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule
